// File: rtl/trg_pkg.sv
// Shared definitions for the trigger frame packer: frame magics, header/footer
// field offsets and the frame FSM state encoding.
package trg_pkg;

  localparam logic [7:0] HDR_MAGIC = 8'hA5;
  localparam logic [7:0] FTR_MAGIC = 8'h5A;

  localparam int MAGIC_LSB     = 120;
  localparam int HDR_TS_LSB    = 72;
  localparam int HDR_BL_LSB    = 60;
  localparam int HDR_TH_LSB    = 47;
  localparam int HDR_SEQ_LSB   = 32;
  localparam int FTR_CNT_LSB   = 104;
  localparam int FTR_TRUNC_BIT = 103;
  localparam int FTR_SEQ_LSB   = 88;

  localparam int SEQ_W = 15;
  localparam int CNT_W = 16;
  localparam int DROP_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    FOOTER  = 2'd2,
    DISCARD = 2'd3
  } trg_state_e;

endpackage

// File: rtl/trg_frame_fifo.sv
// First-word-fall-through FIFO holding {last,word}; reports free entries so the
// packer can refuse triggers that would not fit.
module trg_frame_fifo #(
  parameter int WIDTH = 129,
  parameter int DEPTH = 256
) (
  input  logic                     CLK,
  input  logic                     RESETN,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   free
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      cnt;
  logic             do_wr, do_rd;

  assign empty = (cnt == '0);
  assign full  = (cnt == DEPTH_C);
  assign free  = DEPTH_C - cnt;
  // A read in the same cycle makes room, so a full FIFO can still accept a write.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);
  assign rd_data = mem[rptr];

  always_ff @(posedge CLK) begin
    if (do_wr) mem[wptr] <= wr_data;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, do_wr} - {{AW{1'b0}}, do_rd};
    end
  end

endmodule

// File: rtl/trg_frame_packer.sv
// Frames triggered ADC words into header/data/footer packets on an AXI4-Stream
// master, and tells the trigger block when a whole frame can be accepted.
module trg_frame_packer
  import trg_pkg::*;
#(
  parameter int TDATA_WIDTH          = 128,
  parameter int TIME_STAMP_WIDTH     = 48,
  parameter int ADC_RESOLUTION_WIDTH = 12,
  parameter int ACQUI_LEN            = 100,
  parameter int FIFO_DEPTH           = 256
) (
  input  logic                            CLK,
  input  logic                            RESETN,
  input  logic                            TRIGGERED,
  input  logic [TDATA_WIDTH-1:0]          DATA,
  input  logic                            VALID,
  input  logic [TIME_STAMP_WIDTH-1:0]     TIME_STAMP,
  input  logic [ADC_RESOLUTION_WIDTH-1:0] BASELINE_WHEN_HIT,
  input  logic [ADC_RESOLUTION_WIDTH:0]   THRESHOLD_WHEN_HIT,
  output logic                            ALL_MODULE_READY,
  output logic [TDATA_WIDTH-1:0]          M_AXIS_TDATA,
  output logic                            M_AXIS_TVALID,
  input  logic                            M_AXIS_TREADY,
  output logic                            M_AXIS_TLAST,
  output logic [DROP_W-1:0]               DROPPED_FRAMES
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] NEED = (AW+1)'(ACQUI_LEN + 2);

  trg_state_e st, st_nxt;

  logic                   trig_d, valid_d;
  logic [TDATA_WIDTH-1:0] data_d;
  logic [SEQ_W-1:0]       seq;
  logic [CNT_W-1:0]       wcnt;
  logic                   trunc, drop_pend, ready_q;
  logic [DROP_W-1:0]      dropped;

  logic                   rise, fall, room, wr_ok;
  logic                   fifo_wr, fifo_rd, fifo_full, fifo_empty;
  logic [AW:0]            fifo_free, free_after;
  logic [TDATA_WIDTH:0]   fifo_din, fifo_dout;
  logic [TDATA_WIDTH-1:0] hdr_word, ftr_word;
  logic                   hdr_load, data_try, ftr_done, drop_inc, drop_pend_set;

  assign rise    = TRIGGERED && !trig_d;
  assign fall    = !TRIGGERED && trig_d;
  assign room    = (fifo_free >= NEED);
  assign fifo_rd = !fifo_empty && M_AXIS_TREADY;
  assign wr_ok   = !fifo_full || fifo_rd;

  always_comb begin
    hdr_word = '0;
    hdr_word[MAGIC_LSB +: 8]                            = HDR_MAGIC;
    hdr_word[HDR_TS_LSB +: TIME_STAMP_WIDTH]            = TIME_STAMP;
    hdr_word[HDR_BL_LSB +: ADC_RESOLUTION_WIDTH]        = BASELINE_WHEN_HIT;
    hdr_word[HDR_TH_LSB +: ADC_RESOLUTION_WIDTH+1]      = THRESHOLD_WHEN_HIT;
    hdr_word[HDR_SEQ_LSB +: SEQ_W]                      = seq;
    ftr_word = '0;
    ftr_word[MAGIC_LSB +: 8]       = FTR_MAGIC;
    ftr_word[FTR_CNT_LSB +: CNT_W] = wcnt;
    ftr_word[FTR_TRUNC_BIT]        = trunc;
    ftr_word[FTR_SEQ_LSB +: SEQ_W] = seq;
  end

  always_comb begin
    st_nxt        = st;
    fifo_wr       = 1'b0;
    fifo_din      = '0;
    hdr_load      = 1'b0;
    data_try      = 1'b0;
    ftr_done      = 1'b0;
    drop_inc      = 1'b0;
    drop_pend_set = 1'b0;
    case (st)
      IDLE: begin
        if (rise) begin
          if (room) begin
            fifo_wr  = 1'b1;
            fifo_din = {1'b0, hdr_word};
            hdr_load = 1'b1;
            st_nxt   = CAPTURE;
          end else begin
            drop_inc = 1'b1;
            st_nxt   = DISCARD;
          end
        end
      end
      CAPTURE: begin
        if (trig_d && valid_d) begin
          fifo_wr  = 1'b1;
          fifo_din = {1'b0, data_d};
          data_try = 1'b1;
        end
        if (fall) st_nxt = FOOTER;
      end
      FOOTER: begin
        // The footer is never dropped; a full FIFO holds the FSM here instead.
        fifo_wr  = 1'b1;
        fifo_din = {1'b1, ftr_word};
        drop_inc = rise;
        if (wr_ok) begin
          ftr_done = 1'b1;
          st_nxt   = (rise || drop_pend) ? DISCARD : IDLE;
        end else begin
          drop_pend_set = rise;
        end
      end
      DISCARD: begin
        if (!TRIGGERED) st_nxt = IDLE;
      end
      default: st_nxt = IDLE;
    endcase
  end

  assign free_after = fifo_free - {{AW{1'b0}}, fifo_wr && wr_ok};

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      st        <= IDLE;
      trig_d    <= 1'b0;
      valid_d   <= 1'b0;
      data_d    <= '0;
      seq       <= '0;
      wcnt      <= '0;
      trunc     <= 1'b0;
      drop_pend <= 1'b0;
      dropped   <= '0;
      ready_q   <= 1'b0;
    end else begin
      st      <= st_nxt;
      trig_d  <= TRIGGERED;
      valid_d <= VALID;
      data_d  <= DATA;
      if (hdr_load) begin
        wcnt  <= '0;
        trunc <= 1'b0;
      end else if (data_try) begin
        if (!wr_ok)           trunc <= 1'b1;
        else if (wcnt != '1)  wcnt  <= wcnt + 1'b1;
      end
      if (ftr_done) begin
        seq       <= seq + 1'b1;
        drop_pend <= 1'b0;
      end else if (drop_pend_set) begin
        drop_pend <= 1'b1;
      end
      if (drop_inc && dropped != '1) dropped <= dropped + 1'b1;
      // Account for this cycle's write so READY never advertises room already spent.
      ready_q <= (st_nxt == IDLE) && (free_after >= NEED);
    end
  end

  trg_frame_fifo #(
    .WIDTH (TDATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RESETN  (RESETN),
    .wr_en   (fifo_wr),
    .wr_data (fifo_din),
    .rd_en   (fifo_rd),
    .rd_data (fifo_dout),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .free    (fifo_free)
  );

  assign ALL_MODULE_READY = ready_q;
  assign DROPPED_FRAMES   = dropped;
  assign M_AXIS_TVALID    = !fifo_empty;
  assign M_AXIS_TDATA     = fifo_empty ? '0 : fifo_dout[TDATA_WIDTH-1:0];
  assign M_AXIS_TLAST     = !fifo_empty && fifo_dout[TDATA_WIDTH];

endmodule

// File: tb/tb_trg_frame_packer.sv
// Directed bench for trg_frame_packer: frame layout, back-pressure, gaps,
// FIFO-full truncation and refusal, refused re-trigger, reset mid-frame.
module tb_trg_frame_packer;

  logic         CLK = 1'b0;
  logic         RESETN = 1'b0;
  logic         TRIGGERED = 1'b0;
  logic [127:0] DATA = '0;
  logic         VALID = 1'b0;
  logic [47:0]  TIME_STAMP = '0;
  logic [11:0]  BASELINE_WHEN_HIT = '0;
  logic [12:0]  THRESHOLD_WHEN_HIT = '0;
  logic         ALL_MODULE_READY;
  logic [127:0] M_AXIS_TDATA;
  logic         M_AXIS_TVALID;
  logic         M_AXIS_TREADY = 1'b0;
  logic         M_AXIS_TLAST;
  logic [15:0]  DROPPED_FRAMES;

  int n_chk = 0;
  int n_fail = 0;

  logic [128:0] got_q[$];
  logic [128:0] exp_q[$];
  logic         stall_seen = 1'b0;
  logic [128:0] held = '0;

  always #5 CLK = ~CLK;

  trg_frame_packer #(
    .TDATA_WIDTH          (128),
    .TIME_STAMP_WIDTH     (48),
    .ADC_RESOLUTION_WIDTH (12),
    .ACQUI_LEN            (12),
    .FIFO_DEPTH           (16)
  ) dut (
    .CLK                (CLK),
    .RESETN             (RESETN),
    .TRIGGERED          (TRIGGERED),
    .DATA               (DATA),
    .VALID              (VALID),
    .TIME_STAMP         (TIME_STAMP),
    .BASELINE_WHEN_HIT  (BASELINE_WHEN_HIT),
    .THRESHOLD_WHEN_HIT (THRESHOLD_WHEN_HIT),
    .ALL_MODULE_READY   (ALL_MODULE_READY),
    .M_AXIS_TDATA       (M_AXIS_TDATA),
    .M_AXIS_TVALID      (M_AXIS_TVALID),
    .M_AXIS_TREADY      (M_AXIS_TREADY),
    .M_AXIS_TLAST       (M_AXIS_TLAST),
    .DROPPED_FRAMES     (DROPPED_FRAMES)
  );

  task automatic chk(input string tag, input logic [128:0] act, input logic [128:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  function automatic logic [127:0] hdr(input logic [47:0] ts, input logic [11:0] bl,
                                       input logic [12:0] th, input logic [14:0] sq);
    return {8'hA5, ts, bl, th, sq, 32'h0};
  endfunction

  function automatic logic [127:0] ftr(input logic [15:0] cnt, input logic tr, input logic [14:0] sq);
    return {8'h5A, cnt, tr, sq, 88'h0};
  endfunction

  function automatic logic [127:0] dw(input int t, input int i);
    logic [31:0] tv, iv;
    tv = t;
    iv = i;
    return {96'hC0DE_0000_0000_0000_0000_0000, tv[15:0], iv[15:0]};
  endfunction

  // Output monitor: records every accepted beat and checks hold-while-stalled.
  always @(negedge CLK) begin
    if (!RESETN) begin
      stall_seen = 1'b0;
    end else begin
      if (stall_seen && M_AXIS_TVALID) chk("hold_stable", {M_AXIS_TLAST, M_AXIS_TDATA}, held);
      if (M_AXIS_TVALID && M_AXIS_TREADY) got_q.push_back({M_AXIS_TLAST, M_AXIS_TDATA});
      stall_seen = M_AXIS_TVALID && !M_AXIS_TREADY;
      held = {M_AXIS_TLAST, M_AXIS_TDATA};
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESETN = 1'b0;
    TRIGGERED = 1'b0;
    VALID = 1'b0;
    @(negedge CLK);
    chk("rst_tvalid", M_AXIS_TVALID, 0);
    chk("rst_tlast", M_AXIS_TLAST, 0);
    chk("rst_tdata", M_AXIS_TDATA, 0);
    chk("rst_ready", ALL_MODULE_READY, 0);
    chk("rst_dropped", DROPPED_FRAMES, 0);
    cyc();
    cyc();
    RESETN = 1'b1;
    @(negedge CLK);
    chk("rel_ready_low", ALL_MODULE_READY, 0);
    @(negedge CLK);
    chk("rel_ready_high", ALL_MODULE_READY, 1);
    cyc();
    got_q.delete();
  endtask

  task automatic wait_idle(input int max);
    bit ok = 1'b0;
    for (int n = 0; n < max && !ok; n++) begin
      @(negedge CLK);
      ok = ALL_MODULE_READY && !M_AXIS_TVALID;
    end
    if (!ok) chk("idle_timeout", 0, 1);
    cyc();
  endtask

  task automatic check_frame(input string tag);
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic set_hit(input logic [47:0] ts, input logic [11:0] bl, input logic [12:0] th);
    TIME_STAMP = ts;
    BASELINE_WHEN_HIT = bl;
    THRESHOLD_WHEN_HIT = th;
  endtask

  initial begin
    do_reset();

    // 1: plain 10-word window, free-running sink
    set_hit(48'h123456, 12'hFFB, 13'h0040);
    M_AXIS_TREADY = 1'b1;
    for (int c = 0; c < 10; c++) begin
      TRIGGERED = 1'b1; VALID = 1'b1; DATA = dw(1, c);
      @(negedge CLK);
      if (c == 0) chk("t1_tvalid_rise", M_AXIS_TVALID, 0);
      if (c == 1) begin
        chk("t1_tvalid_hdr", M_AXIS_TVALID, 1);
        chk("t1_hdr_first", M_AXIS_TDATA, hdr(48'h123456, 12'hFFB, 13'h0040, 15'd0));
      end
      cyc();
    end
    TRIGGERED = 1'b0; VALID = 1'b0;
    wait_idle(200);
    exp_q.push_back({1'b0, hdr(48'h123456, 12'hFFB, 13'h0040, 15'd0)});
    for (int c = 0; c < 10; c++) exp_q.push_back({1'b0, dw(1, c)});
    exp_q.push_back({1'b1, ftr(16'd10, 1'b0, 15'd0)});
    check_frame("t1");

    // 2: same frame shape with TREADY toggling
    set_hit(48'h123456, 12'hFFB, 13'h0040);
    for (int c = 0; c < 40; c++) begin
      TRIGGERED = (c < 10); VALID = 1'b1; DATA = dw(2, c);
      M_AXIS_TREADY = (c % 2 == 0);
      cyc();
    end
    TRIGGERED = 1'b0; VALID = 1'b0; M_AXIS_TREADY = 1'b1;
    wait_idle(200);
    exp_q.push_back({1'b0, hdr(48'h123456, 12'hFFB, 13'h0040, 15'd1)});
    for (int c = 0; c < 10; c++) exp_q.push_back({1'b0, dw(2, c)});
    exp_q.push_back({1'b1, ftr(16'd10, 1'b0, 15'd1)});
    check_frame("t2");

    // 3: VALID low for 3 cycles inside the window
    set_hit(48'hABCDEF012345, 12'h07F, 13'h1F00);
    for (int c = 0; c < 10; c++) begin
      TRIGGERED = 1'b1; VALID = !(c >= 4 && c <= 6); DATA = dw(3, c);
      cyc();
    end
    TRIGGERED = 1'b0; VALID = 1'b0;
    wait_idle(200);
    exp_q.push_back({1'b0, hdr(48'hABCDEF012345, 12'h07F, 13'h1F00, 15'd2)});
    for (int c = 0; c < 10; c++) if (!(c >= 4 && c <= 6)) exp_q.push_back({1'b0, dw(3, c)});
    exp_q.push_back({1'b1, ftr(16'd7, 1'b0, 15'd2)});
    check_frame("t3");

    // 4: stalled sink, 20-word window overflows the 16-entry FIFO
    set_hit(48'h0000_0000_0444, 12'h800, 13'h0FFF);
    M_AXIS_TREADY = 1'b0;
    @(negedge CLK);
    chk("t4_ready_before", ALL_MODULE_READY, 1);
    cyc();
    for (int c = 0; c < 20; c++) begin
      TRIGGERED = 1'b1; VALID = 1'b1; DATA = dw(4, c);
      cyc();
    end
    TRIGGERED = 1'b0; VALID = 1'b0;
    repeat (4) cyc();
    @(negedge CLK);
    chk("t4_ready_stalled", ALL_MODULE_READY, 0);
    cyc();
    M_AXIS_TREADY = 1'b1;
    cyc();
    M_AXIS_TREADY = 1'b0;
    cyc();
    cyc();
    @(negedge CLK);
    chk("t4_ready_full", ALL_MODULE_READY, 0);
    cyc();
    for (int c = 0; c < 3; c++) begin
      TRIGGERED = 1'b1; VALID = 1'b1; DATA = dw(44, c);
      cyc();
    end
    TRIGGERED = 1'b0; VALID = 1'b0;
    repeat (3) cyc();
    @(negedge CLK);
    chk("t4_dropped", DROPPED_FRAMES, 1);
    cyc();
    M_AXIS_TREADY = 1'b1;
    wait_idle(200);
    exp_q.push_back({1'b0, hdr(48'h0000_0000_0444, 12'h800, 13'h0FFF, 15'd3)});
    for (int c = 0; c < 15; c++) exp_q.push_back({1'b0, dw(4, c)});
    exp_q.push_back({1'b1, ftr(16'd15, 1'b1, 15'd3)});
    check_frame("t4");

    // 5: re-trigger one cycle after the fall lands in FOOTER and is refused
    do_reset();
    set_hit(48'h0000_5555_0001, 12'h001, 13'h0002);
    M_AXIS_TREADY = 1'b1;
    for (int c = 0; c < 10; c++) begin
      TRIGGERED = (c != 5); VALID = 1'b1; DATA = dw(5, c);
      cyc();
    end
    TRIGGERED = 1'b0; VALID = 1'b0;
    wait_idle(200);
    @(negedge CLK);
    chk("t5_dropped", DROPPED_FRAMES, 1);
    cyc();
    exp_q.push_back({1'b0, hdr(48'h0000_5555_0001, 12'h001, 13'h0002, 15'd0)});
    for (int c = 0; c < 5; c++) exp_q.push_back({1'b0, dw(5, c)});
    exp_q.push_back({1'b1, ftr(16'd5, 1'b0, 15'd0)});
    check_frame("t5");

    // 6: reset in the middle of a capture window
    set_hit(48'h0000_6666_0000, 12'h00A, 13'h000B);
    for (int c = 0; c < 6; c++) begin
      TRIGGERED = 1'b1; VALID = 1'b1; DATA = dw(6, c);
      cyc();
    end
    do_reset();
    @(negedge CLK);
    chk("t6_fifo_empty", M_AXIS_TVALID, 0);
    cyc();
    set_hit(48'h0000_6666_0001, 12'h00C, 13'h000D);
    for (int c = 0; c < 4; c++) begin
      TRIGGERED = 1'b1; VALID = 1'b1; DATA = dw(7, c);
      cyc();
    end
    TRIGGERED = 1'b0; VALID = 1'b0;
    wait_idle(200);
    exp_q.push_back({1'b0, hdr(48'h0000_6666_0001, 12'h00C, 13'h000D, 15'd0)});
    for (int c = 0; c < 4; c++) exp_q.push_back({1'b0, dw(7, c)});
    exp_q.push_back({1'b1, ftr(16'd4, 1'b0, 15'd0)});
    check_frame("t6");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
